lsu_ctrl: RTL and testbench

- Load/store control unit sitting directly upstream of the data memory.
- Accepts one memory operation at a time from the pipeline MEM stage over a valid/ready handshake.
- Drives the memory's request, write-enable, word address, byte mask and write data, and waits for the memory's registered valid.
- Returns an aligned, sign- or zero-extended load result (or store completion) as a one-cycle response, with a pipeline stall while busy.

---
 rtl/lsu_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store control unit placed directly in front of the data
//                memory. Takes one operation at a time from the MEM stage over
//                a valid/ready handshake, issues the memory access with the
//                correct byte lanes, waits for the memory's registered valid,
//                and returns an extended load result (or store completion) as
//                a one-cycle response. The pipeline is stalled while busy.
//
//  Ports       : clk, rst                 clock / synchronous active-high reset
//                req_valid, req_ready     operation handshake from the pipeline
//                req_store, req_addr,     operation fields (byte address, store
//                req_wdata, req_fun3      data right-justified, RV32 funct3)
//                resp_valid, resp_rdata,  one-cycle response, extended data,
//                resp_err                 error flag (misaligned/illegal/timeout)
//                stall                    busy indication to the pipeline
//                mem_request, mem_we_re,  memory request, write enable,
//                mem_load, mem_address,   load strobe, word address,
//                mem_mask, mem_wdata      byte write mask, lane-replicated data
//                mem_rdata, mem_valid     async read data, registered valid
//
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // pipeline request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_fun3,
  // pipeline response
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              stall,
  // data memory
  output logic              mem_request,
  output logic              mem_we_re,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_mask,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_valid
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // Counter value seen in the last ACCESS cycle allowed before giving up.
  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_next;

  // Latched operation
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_fun3;
  logic              r_store;
  logic [7:0]        r_cnt;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_illegal;
  logic              w_accept;
  logic              w_timeout;
  logic [31:0]       w_load_data;
  logic [3:0]        w_store_mask;
  logic [31:0]       w_store_data;

  // Only word-address bits of the byte address reach the memory.
  logic              w_unused_addr;
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  // --------------------------------------------------------------------------
  // Request legality, evaluated on the live request in the accept cycle.
  // funct3[1:0] encodes size (byte/half/word); funct3[2] is the unsigned flag
  // which only exists for byte and halfword loads.
  // --------------------------------------------------------------------------
  always_comb begin
    w_illegal = 1'b0;
    if (req_store) begin
      if (req_fun3[2] || (req_fun3[1:0] == 2'b11))
        w_illegal = 1'b1;
    end else begin
      if ((req_fun3 == 3'b011) || (req_fun3 == 3'b110) || (req_fun3 == 3'b111))
        w_illegal = 1'b1;
    end
    // Halfword may straddle lanes 1-2 but must not cross the word boundary.
    if ((req_fun3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11))
      w_illegal = 1'b1;
    if ((req_fun3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
      w_illegal = 1'b1;
  end

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign stall     = (r_state != S_IDLE) || w_accept;
  assign w_timeout = (r_cnt == c_cnt_last);

  // --------------------------------------------------------------------------
  // Load extraction: shift the addressed byte/halfword down to bit 0, then
  // sign- or zero-extend according to funct3.
  // --------------------------------------------------------------------------
  function automatic logic [31:0] f_extract(input logic [31:0] word,
                                            input logic [1:0]  b,
                                            input logic [2:0]  fun3);
    logic [31:0] shifted;
    shifted = word >> {b, 3'b000};
    case (fun3)
      3'b000:  f_extract = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  f_extract = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  f_extract = {24'd0, shifted[7:0]};
      3'b101:  f_extract = {16'd0, shifted[15:0]};
      default: f_extract = word;
    endcase
  endfunction

  assign w_load_data = f_extract(mem_rdata, r_addr[1:0], r_fun3);

  // --------------------------------------------------------------------------
  // Store lane steering. Data is replicated across all lanes so that unused
  // lanes are deterministic; the mask selects which lanes are written.
  // --------------------------------------------------------------------------
  always_comb begin
    w_store_mask = 4'b0000;
    w_store_data = r_wdata;
    case (r_fun3[1:0])
      2'b00: begin
        w_store_mask = 4'b0001 << r_addr[1:0];
        w_store_data = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        case (r_addr[1:0])
          2'b00:   w_store_mask = 4'b0011;
          2'b01:   w_store_mask = 4'b0110;
          default: w_store_mask = 4'b1100;
        endcase
        // Offset 1 needs the halfword centred on lanes 1-2.
        if (r_addr[0])
          w_store_data = {r_wdata[7:0], r_wdata[15:0], r_wdata[15:8]};
        else
          w_store_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_store_mask = 4'b1111;
        w_store_data = r_wdata;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = w_illegal ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        // A store's write lands on the closing edge of its only ACCESS cycle.
        if (r_store || mem_valid || w_timeout)
          w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operation latch, timeout counter and response capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_fun3  <= '0;
      r_store <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr[ADDR_W+1:0];
            r_wdata <= req_wdata;
            r_fun3  <= req_fun3;
            r_store <= req_store;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= w_illegal;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 8'd1;
          // mem_valid takes priority over a timeout landing in the same cycle.
          if (!r_store) begin
            if (mem_valid)
              r_rdata <= w_load_data;
            else if (w_timeout)
              r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    resp_valid  = 1'b0;
    resp_rdata  = 32'd0;
    resp_err    = 1'b0;
    mem_request = 1'b0;
    mem_we_re   = 1'b0;
    mem_load    = 1'b0;
    mem_address = '0;
    mem_mask    = 4'b0000;
    mem_wdata   = 32'd0;
    case (r_state)
      S_ACCESS: begin
        mem_request = 1'b1;
        mem_we_re   = r_store;
        mem_load    = !r_store;
        mem_address = r_addr[ADDR_W+1:2];
        if (r_store) begin
          mem_mask  = w_store_mask;
          mem_wdata = w_store_data;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = r_rdata;
        resp_err   = r_err;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Self-checking bench for lsu_ctrl. A byte-level reference
//                model predicts each operation's outcome and cycle timeline;
//                one compare process checks DUT outputs every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;

  localparam int ADDR_W  = 8;
  localparam int TO      = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_store;
  logic [31:0]       req_addr, req_wdata;
  logic [2:0]        req_fun3;
  logic              resp_valid, resp_err, stall;
  logic [31:0]       resp_rdata;
  logic              mem_request, mem_we_re, mem_load;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_mask;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic rst_q = 1'b0;

  lsu_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_fun3(req_fun3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_load(mem_load),
    .mem_address(mem_address), .mem_mask(mem_mask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- memory model (driven by DUT) ----------------
  logic [31:0] bmem [256];
  logic        mem_init;
  int          mem_lat = 1;
  int          acc_cnt = 0;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign mem_rdata = (mem_request && !mem_we_re) ? bmem[mem_address] : 32'hDEAD_0BAD;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) bmem[i] <= init_word(i);
    end else if (mem_request && mem_we_re) begin
      for (int k = 0; k < 4; k++)
        if (mem_mask[k]) bmem[mem_address][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
    if (mem_request && !mem_we_re) begin
      acc_cnt   <= acc_cnt + 1;
      mem_valid <= (acc_cnt + 1 == mem_lat);
    end else begin
      acc_cnt   <= 0;
      mem_valid <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [256];
  bit          op_act = 0;
  int          op_acc, op_nacc;
  bit          op_st, op_err;
  logic [31:0] op_addr, op_rd;
  logic [3:0]  op_mask;
  logic [7:0]  op_lane [4];

  task automatic set_op(input bit st, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f, input int lat);
    int b, nb, idx;
    bit legal;
    logic [31:0] val;
    b  = int'(a[1:0]);
    nb = 1 << f[1:0];
    idx = int'(a[9:2]);
    legal = st ? (f inside {3'd0, 3'd1, 3'd2}) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (b + nb > 4) legal = 0;          // access must fit inside one word
    op_st = st; op_addr = a; op_mask = 4'b0; op_rd = 32'd0; op_err = 0;
    for (int i = 0; i < 4; i++) op_lane[i] = 8'd0;
    if (!legal) begin
      op_nacc = 0; op_err = 1;
    end else if (st) begin
      op_nacc = 1;
      for (int i = 0; i < nb; i++) begin
        op_mask[b+i] = 1'b1;
        op_lane[b+i] = wd[8*i +: 8];
        ref_mem[idx][8*(b+i) +: 8] = wd[8*i +: 8];
      end
    end else if (lat >= 1 && lat + 1 <= TO) begin
      op_nacc = lat + 1;
      val = 32'd0;
      for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_mem[idx][8*(b+i) +: 8];
      if (!f[2] && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
      op_rd = val;
    end else begin
      op_nacc = TO; op_err = 1;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  int ph;
  always @(negedge clk) begin
    if (op_act) begin
      ph = cyc - op_acc;
      chk("stall_busy", 32'(stall), 32'd1);
      if (ph == 0) begin
        chk("accept_ready", 32'(req_ready), 32'd1);
        chk("accept_mem_request", 32'(mem_request), 32'd0);
        chk("accept_resp_valid", 32'(resp_valid), 32'd0);
      end else if (ph <= op_nacc) begin
        chk("acc_mem_request", 32'(mem_request), 32'd1);
        chk("acc_we_re", 32'(mem_we_re), 32'(op_st));
        chk("acc_load", 32'(mem_load), 32'(!op_st));
        chk("acc_address", 32'(mem_address), 32'(op_addr[9:2]));
        chk("acc_mask", 32'(mem_mask), 32'(op_mask));
        chk("acc_resp_valid", 32'(resp_valid), 32'd0);
        chk("acc_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 4; k++)
          if (op_mask[k]) chk("acc_wdata_lane", 32'(mem_wdata[8*k +: 8]), 32'(op_lane[k]));
      end else if (ph == op_nacc + 1) begin
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_err", 32'(resp_err), 32'(op_err));
        chk("resp_rdata", resp_rdata, op_rd);
        chk("resp_mem_request", 32'(mem_request), 32'd0);
        chk("resp_ready", 32'(req_ready), 32'd0);
      end
    end else begin
      chk("idle_resp_valid", 32'(resp_valid), 32'd0);
      chk("idle_mem_request", 32'(mem_request), 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_ready", 32'(req_ready), 32'(!rst));
      if (rst_q) begin
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_we_re", 32'(mem_we_re), 32'd0);
        chk("rst_mem_load", 32'(mem_load), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_mask", 32'(mem_mask), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  // Entered at posedge+#1 of a cycle in which the DUT is idle.
  task automatic do_op(input bit st, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f, input int lat, input bit abort,
                       output logic [31:0] rd, output bit er, output int nreq);
    int end_cyc;
    set_op(st, a, wd, f, lat);
    mem_lat = lat;
    op_acc = cyc;
    op_act = 1;
    req_valid = 1; req_store = st; req_addr = a; req_wdata = wd; req_fun3 = f;
    nreq = 0; rd = 32'd0; er = 0;
    end_cyc = abort ? op_acc + 2 : op_acc + op_nacc + 2;
    while (cyc < end_cyc) begin
      @(negedge clk);
      if (mem_request) nreq++;
      if (resp_valid) begin rd = resp_rdata; er = resp_err; end
      @(posedge clk); #1;
      // Busy-time changes on req_* must not disturb the operation in flight.
      req_valid = 0;
      req_store = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      req_fun3 = 3'($urandom);
      if (abort) rst = (cyc == op_acc + 1);
    end
    rst = 0;
    op_act = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, wd;
    logic [2:0]  f;
    bit er, st;
    int nreq, lat;
    int lats [6] = '{0, 1, 1, 1, 2, 3};

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst = 1; mem_init = 1;
    req_valid = 0; req_store = 0; req_addr = 0; req_wdata = 0; req_fun3 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0; mem_init = 0;
    @(negedge clk);
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // SW 0x10 DEADBEEF
    do_op(1, 32'h10, 32'hDEAD_BEEF, 3'b010, 1, 0, rd, er, nreq);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_nreq", 32'(nreq), 32'd1);
    chk("sw_mem_word", bmem[4], 32'hDEAD_BEEF);
    // Put 0x80FF1234 into word 4, then LB / LBU at 0x13
    do_op(1, 32'h10, 32'h80FF_1234, 3'b010, 1, 0, rd, er, nreq);
    do_op(0, 32'h13, 32'h0, 3'b000, 1, 0, rd, er, nreq);
    chk("lb_rdata", rd, 32'hFFFF_FF80);
    chk("lb_nreq", 32'(nreq), 32'd2);
    do_op(0, 32'h13, 32'h0, 3'b100, 1, 0, rd, er, nreq);
    chk("lbu_rdata", rd, 32'h0000_0080);
    // SH 0x21 then LHU 0x21
    do_op(1, 32'h21, 32'h0000_ABCD, 3'b001, 1, 0, rd, er, nreq);
    chk("sh_mem_bytes", 32'(bmem[8][23:8]), 32'h0000_ABCD);
    do_op(0, 32'h21, 32'h0, 3'b101, 1, 0, rd, er, nreq);
    chk("lhu_rdata", rd, 32'h0000_ABCD);
    // Misaligned LW / LH
    do_op(0, 32'h02, 32'h0, 3'b010, 1, 0, rd, er, nreq);
    chk("lw_mis_err", 32'(er), 32'd1);
    chk("lw_mis_rdata", rd, 32'd0);
    chk("lw_mis_nreq", 32'(nreq), 32'd0);
    do_op(0, 32'h03, 32'h0, 3'b001, 1, 0, rd, er, nreq);
    chk("lh_mis_err", 32'(er), 32'd1);
    chk("lh_mis_nreq", 32'(nreq), 32'd0);
    // Timeout: memory never answers
    do_op(0, 32'h40, 32'h0, 3'b010, 0, 0, rd, er, nreq);
    chk("timeout_err", 32'(er), 32'd1);
    chk("timeout_nreq", 32'(nreq), 32'(TO));
    chk("timeout_rdata", rd, 32'd0);
    // Reset during a load's ACCESS cycle, then a normal LW
    do_op(0, 32'h10, 32'h0, 3'b010, 1, 1, rd, er, nreq);
    chk("abort_no_resp", 32'(rd), 32'd0);
    do_op(0, 32'h10, 32'h0, 3'b010, 1, 0, rd, er, nreq);
    chk("after_abort_lw", rd, 32'h80FF_1234);
    chk("after_abort_err", 32'(er), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom);
      if ($urandom_range(0, 3) == 0) f = 3'($urandom);
      else if (st) f = 3'($urandom_range(0, 2));
      else begin
        f = 3'($urandom_range(0, 4));
        if (f == 3'd3) f = 3'd4;
        else if (f == 3'd4) f = 3'd5;
      end
      a  = $urandom;
      if ($urandom_range(0, 2) != 0 && f[1:0] == 2'b10) a[1:0] = 2'b00;
      wd = $urandom;
      lat = lats[$urandom_range(0, 5)];
      do_op(st, a, wd, f, lat, 0, rd, er, nreq);
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
